reg_dump_reader: RTL and testbench

Debug read-out engine for the unicycle register bank. On a `start` pulse it freezes core register writes, walks every register through one bank read port, and streams each (address, value) pair out over a valid/ready handshake. It sits beside `regBank`, sharing a read-address port through a debug mux, and feeds a debug UART or trace buffer.

---
 rtl/reg_dump_reader.sv | 138 +++++++++++++
 tb/tb_reg_dump_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// ---------------------------------------------------------------------------
// reg_dump_reader
//
// Debug read-out engine for the register bank. A start pulse freezes core
// register writes, walks every register through one bank read port and
// streams each (address, value) pair out over a valid/ready handshake.
//
// Parameters:
//   WIDTH  register data width
//   DEPTH  number of registers (power of two, >= 2)
//   AW     register address width, $clog2(DEPTH)
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   dump request, only honoured while idle
//   ra         out  read address to the bank read port
//   rd         in   combinational bank read data for ra
//   freeze     out  core must hold bank write enable low while high
//   busy       out  engine is not idle
//   done       out  one-cycle pulse after the last pair is accepted
//   out_valid  out  current pair is valid
//   out_ready  in   consumer accepts the current pair
//   out_addr   out  register index of the current pair
//   out_data   out  register value of the current pair
// ---------------------------------------------------------------------------
module reg_dump_reader #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [AW-1:0]    ra,
  input  logic [WIDTH-1:0] rd,
  output logic             freeze,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_addr,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREEZE,
    S_READ,
    S_SEND,
    S_DONE
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    out_addr_q, out_addr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic xfer;

  assign xfer = (state_q == S_SEND) && out_ready;

  // Next-state logic. The captured pair only changes in READ, so it stays
  // stable for as long as SEND is stalled by the consumer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_FREEZE;
        end
      end
      // One settling cycle: a write committed on the edge that sampled
      // start has landed in the bank before the first read.
      S_FREEZE: begin
        state_d = S_READ;
      end
      S_READ: begin
        out_data_d = rd;
        out_addr_d = idx_q;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          // Terminal compare ends the walk before idx could wrap.
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  // Outputs decode directly from the state register, so none of them has a
  // combinational path from rd or out_ready.
  assign ra        = ((state_q == S_READ) || (state_q == S_SEND)) ? idx_q : '0;
  assign freeze    = (state_q == S_FREEZE) || (state_q == S_READ) || (state_q == S_SEND);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_valid = (state_q == S_SEND);
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_reader
//
// Self-checking bench for reg_dump_reader. A small register bank lives in the
// bench and is wired to the read port; core writes into it are gated by the
// DUT's freeze. The reference model keeps its own copy of the bank contents
// and predicts every cycle of a dump from the timing rules: pair i becomes
// valid two cycles after the previous transfer (three after start), transfers
// whenever ready is high while valid, and done follows the last transfer.
// ---------------------------------------------------------------------------
module tb_reg_dump_reader;

  localparam int WIDTH  = 64;
  localparam int DEPTH  = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int BUDGET = 2000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [AW-1:0]    ra;
  logic [WIDTH-1:0] rd;
  logic             freeze;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_addr;
  logic [WIDTH-1:0] out_data;

  // Bench-side bank and core write port.
  logic             wen;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] bank     [DEPTH];
  logic [WIDTH-1:0] exp_bank [DEPTH];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit tog      = 1'b0;

  reg_dump_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ra        (ra),
    .rd        (rd),
    .freeze    (freeze),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // x0 is hardwired to zero in the bank.
  assign rd = (ra == '0) ? '0 : bank[ra];

  always @(posedge clk) begin
    if (wen && !freeze && (wa != '0)) bank[wa] <= wd;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"},  out_valid, 1'b0);
    check({tag, "_freeze"}, freeze,    1'b0);
    check({tag, "_busy"},   busy,      1'b0);
    check({tag, "_done"},   done,      1'b0);
    check({tag, "_ra"},     ra,        '0);
  endtask

  task automatic write_reg(input int a, input logic [WIDTH-1:0] d);
    wen = 1'b1;
    wa  = AW'(a);
    wd  = d;
    if (a != 0) exp_bank[a] = d;
    tick();
    wen = 1'b0;
  endtask

  // Runs one dump starting from an idle cycle.
  //   rmode: 0 ready held high, 1 ready toggles every cycle, 2 random ready
  //   abort_at: index after whose acceptance reset is pulsed (-1: none)
  //   smode: start after launch 0 low, 1 random, 2 held high
  task automatic run_dump(input int rmode, input int abort_at, input int smode,
                          output int done_rel, output int done_abs);
    logic [WIDTH-1:0] snap [DEPTH];
    int  n, i, nv, done_n;
    bit  send, busy_e, freeze_e, done_e, rdy;
    int  ra_e;

    done_rel  = -1;
    done_abs  = -1;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();                       // edge T samples start
    wen = 1'b0;
    for (int k = 0; k < DEPTH; k++) snap[k] = (k == 0) ? '0 : exp_bank[k];

    n = 1; i = 0; nv = 3; done_n = -1;
    forever begin
      if (n > BUDGET) begin
        check("dump_cycle_budget", 64'(n), 64'(BUDGET));
        break;
      end
      if ((done_n >= 0) && (n == done_n + 1)) begin
        check_idle("after_done");
        break;
      end

      send     = (i < DEPTH) && (n >= nv);
      freeze_e = (i < DEPTH);
      done_e   = (n == done_n);
      busy_e   = freeze_e || done_e;
      ra_e     = ((i < DEPTH) && (n >= 2)) ? i : 0;

      check("out_valid", out_valid, send);
      check("freeze",    freeze,    freeze_e);
      check("busy",      busy,      busy_e);
      check("done",      done,      done_e);
      check("ra",        ra,        64'(ra_e));
      if (send) begin
        check("out_addr", out_addr, 64'(i));
        check("out_data", out_data, snap[i]);
      end
      if (done_e) begin
        done_rel = n;
        done_abs = cyc;
      end

      if ((abort_at >= 0) && (i == abort_at + 1)) begin
        reset = 1'b1;
        start = 1'b0;
        wen   = 1'b0;
        tick();
        reset = 1'b0;
        check_idle("abort");
        check("abort_out_addr", out_addr, '0);
        check("abort_out_data", out_data, '0);
        return;
      end

      case (rmode)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = ~tog; end
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      out_ready = rdy;

      case (smode)
        0:       start = 1'b0;
        1:       start = 1'($urandom_range(0, 1));
        default: start = 1'b1;
      endcase

      // Core write attempts; only those issued while unfrozen should land.
      if ($urandom_range(0, 3) == 0) begin
        wen = 1'b1;
        wa  = AW'($urandom_range(0, DEPTH - 1));
        wd  = {$urandom, $urandom};
        if (!freeze_e && (wa != '0)) exp_bank[wa] = wd;
      end else begin
        wen = 1'b0;
      end

      if (send && rdy) begin
        i++;
        nv = n + 2;
        if (i == DEPTH) done_n = n + 1;
      end
      tick();
      n++;
    end
    wen = 1'b0;
  endtask

  initial begin
    int d_rel, d_abs, d1_abs, d2_abs;

    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    wen = 1'b0; wa = '0; wd = '0;
    for (int k = 0; k < DEPTH; k++) exp_bank[k] = '0;
    repeat (3) tick();
    check_idle("reset");
    check("reset_out_addr", out_addr, '0);
    check("reset_out_data", out_data, '0);
    reset = 1'b0;
    tick();
    check_idle("post_reset");

    // Fill the bank, then the named values.
    for (int a = 0; a < DEPTH; a++) write_reg(a, {$urandom, $urandom});
    write_reg(1, 64'd3);
    write_reg(2, 64'hDEAD);
    write_reg(31, '1);

    // Basic dump with ready held high.
    run_dump(0, -1, 0, d_rel, d_abs);
    check("basic_done_at", 64'(d_rel), 64'd66);
    start = 1'b0;
    tick();
    check_idle("gap1");

    // Back-pressure: ready toggles every cycle.
    run_dump(1, -1, 0, d_rel, d_abs);
    start = 1'b0;
    tick();
    check_idle("gap2");

    // Write race plus start pulses while busy.
    wen = 1'b1; wa = AW'(5); wd = 64'd7; exp_bank[5] = 64'd7;
    run_dump(0, -1, 1, d_rel, d_abs);
    check("race_done_at", 64'(d_rel), 64'd66);
    start = 1'b0;
    tick();
    check_idle("gap3");

    // Reset after register 4 is accepted, then a fresh dump from 0.
    run_dump(0, 4, 0, d_rel, d_abs);
    run_dump(2, -1, 0, d_rel, d_abs);
    start = 1'b0;
    tick();
    check_idle("gap4");

    // Back-to-back with start held high.
    run_dump(0, -1, 2, d_rel, d1_abs);
    run_dump(0, -1, 2, d_rel, d2_abs);
    check("b2b_done_spacing", 64'(d2_abs - d1_abs), 64'd67);
    start = 1'b0;
    tick();
    check_idle("gap5");

    // Randomized rounds.
    for (int r = 0; r < 4; r++) begin
      run_dump(2, -1, 1, d_rel, d_abs);
      start = 1'b0;
      tick();
      check_idle("rand_gap");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
